regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised register file with two read ports, two write ports, a per-register busy scoreboard and a sequential clear engine. It sits in the decode/writeback boundary of the pipeline:
- Decode reads operands and busy flags, and marks destinations busy on issue.
- Writeback retires results and clears their busy flags.
- After reset or a flush request, the array is zeroed one entry per cycle before normal operation resumes.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; minimum 2, need not be a power of two.
- AW, $clog2(NREGS), address width; derived, not overridden.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  single-cycle flush request; starts the clear engine.
- i_rs1_addr, i_rs2_addr  in  AW  read addresses.
- o_rs1_data, o_rs2_data  out  XLEN  read data, combinational.
- o_rs1_busy, o_rs2_busy  out  1  scoreboard bit of the read address, combinational.
- i_issue_valid  in  1  marks i_issue_rd busy.
- i_issue_rd  in  AW  destination being issued.
- i_wr0_en, i_wr1_en  in  1  write enables.
- i_wr0_addr, i_wr1_addr  in  AW  write addresses.
- i_wr0_data, i_wr1_data  in  XLEN  write data.
- o_clear_busy  out  1  high while the clear engine runs.

## Operation
State machine with two states, IDLE and CLEAR. A clear index counter of width AW drives the CLEAR state.

Reset (asynchronous, i_rst_n low):
- state = CLEAR, index = 0, all busy bits = 0, o_clear_busy = 1.
- The array itself is not reset; the clear engine zeroes it.

CLEAR state:
- Each cycle writes 0 to entry index and clears its busy bit.
- index increments each cycle.
- The cycle that writes index NREGS-1 is the last clear cycle. The next state is IDLE, and index returns to 0.
- While in CLEAR:
  - write ports and issue are ignored;
  - o_rs*_data = 0 and o_rs*_busy = 0.
- i_clear asserted in CLEAR restarts the sweep at index 0.
- Reset asserted mid-sweep restarts the sweep asynchronously at index 0.

IDLE state:
- i_clear asserted moves to CLEAR next cycle with index 0. Writes and issue in that same cycle are ignored.
- Writes: each enabled port writes its data and clears the busy bit of its address.
- If both ports target the same address, wr1 wins (data and busy clear).
- Issue: i_issue_valid sets busy[i_issue_rd].
- If the same cycle also clears that register through a write port, the set wins: the issued instruction is younger.
- ZERO_REG = 1:
  - address 0 writes and issues have no effect;
  - reads of address 0 return data 0 and busy 0, regardless of bypass.
- Reads are combinational from the array. See Configuration for same-cycle write visibility.

## Timing
- Read latency is 0 cycles (combinational).
- Writes and busy updates become visible in the array at the next rising edge.
- Issue-to-busy-visible latency is 1 cycle.
- Clear sweep takes exactly NREGS cycles from the first CLEAR cycle. o_clear_busy is high for those NREGS cycles and low on the cycle after the last write.
- After reset release, o_clear_busy falls NREGS rising edges later.
- o_clear_busy is a registered output (state == CLEAR); it is not decoded from index.

## Configuration
- REGFILE_SB_BYPASS_EN defined: in IDLE, a read whose address matches an enabled write port in the same cycle returns that port's data. Priority is wr1 over wr0 over array. The busy output is also forwarded: a matching write forces o_rs*_busy = 0, unless a same-cycle issue to that address would set it, in which case the combinational busy still shows 0. The set takes effect next cycle.
- REGFILE_SB_BYPASS_EN undefined: reads return array contents only. Same-cycle writes are visible from the next cycle.
- ZERO_REG and the CLEAR-state forcing to 0 apply in both builds.

## Test plan
- Reset then release: o_clear_busy = 1 for exactly 32 cycles (default NREGS). After that, reading x5 returns 0x00000000 with busy 0.
- Write x3 = 0xDEADBEEF via wr0 while reading x3: with BYPASS_EN the same cycle returns 0xDEADBEEF; without it, the same cycle returns 0 and the next cycle returns 0xDEADBEEF.
- Same-cycle wr0 x7 = 0x11111111 and wr1 x7 = 0x22222222: next cycle x7 reads 0x22222222.
- Issue x9, then next cycle o_rs1_busy = 1 for x9. Later, write x9 together with a same-cycle issue x9: busy stays 1. A write without issue clears it to 0.
- Writes and issue to x0 with ZERO_REG = 1: x0 always reads 0 with busy 0.
- Fill x1..x4 with nonzero values, pulse i_clear: 32 CLEAR cycles ignore a write to x2 issued mid-sweep. Afterwards x1..x4 read 0. A second i_clear at sweep index 10 extends o_clear_busy to 10 + 32 cycles total.

Source files
------------

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: operand read, issue, writeback and flush signals of regfile_sb.
// slave  = register file side, master = pipeline side driving it.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            i_clear;
  logic [AW-1:0]   i_rs1_addr;
  logic [AW-1:0]   i_rs2_addr;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_rs1_busy;
  logic            o_rs2_busy;
  logic            i_issue_valid;
  logic [AW-1:0]   i_issue_rd;
  logic            i_wr0_en;
  logic            i_wr1_en;
  logic [AW-1:0]   i_wr0_addr;
  logic [AW-1:0]   i_wr1_addr;
  logic [XLEN-1:0] i_wr0_data;
  logic [XLEN-1:0] i_wr1_data;
  logic            o_clear_busy;

  modport slave (
    input  i_clear, i_rs1_addr, i_rs2_addr, i_issue_valid, i_issue_rd,
    input  i_wr0_en, i_wr1_en, i_wr0_addr, i_wr1_addr, i_wr0_data, i_wr1_data,
    output o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_clear_busy
  );

  modport master (
    output i_clear, i_rs1_addr, i_rs2_addr, i_issue_valid, i_issue_rd,
    output i_wr0_en, i_wr1_en, i_wr0_addr, i_wr1_addr, i_wr0_data, i_wr1_data,
    input  o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy, o_clear_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/2W register file with per-register busy scoreboard and a
// sequential clear engine that zeroes one entry per cycle after reset/flush.
// Optional macro REGFILE_SB_BYPASS_EN: forward same-cycle writes (data and
// busy) to the read ports while idle. Undefined: reads see the array only.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic [AW-1:0]   w_clr_idx;

  logic [XLEN-1:0] r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  logic [NREGS-1:0] w_clr_hit;
  logic [NREGS-1:0] w_wr0_hit;
  logic [NREGS-1:0] w_wr1_hit;
  logic [NREGS-1:0] w_iss_hit;

  logic w_in_clear;
  logic w_idle_ok;
  logic w_wr0_act;
  logic w_wr1_act;
  logic w_iss_act;

  // Address exists in the array (NREGS need not be a power of two).
  function automatic logic f_in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  // Address may be written or marked busy (x0 is hardwired when ZERO_REG).
  function automatic logic f_writable(input logic [AW-1:0] a);
    return f_in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes and issue only take effect when idle and no flush is requested.
  assign w_in_clear = (r_state == ST_CLEAR);
  assign w_idle_ok  = (r_state == ST_IDLE) && !bus.i_clear;
  assign w_wr0_act  = w_idle_ok && bus.i_wr0_en && f_writable(bus.i_wr0_addr);
  assign w_wr1_act  = w_idle_ok && bus.i_wr1_en && f_writable(bus.i_wr1_addr);
  assign w_iss_act  = w_idle_ok && bus.i_issue_valid && f_writable(bus.i_issue_rd);

  // Clear engine next-state: a flush in CLEAR restarts the sweep at entry 0
  // in the same cycle, so the restart cycle is the first of the new sweep.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_clr_idx    = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_clear) begin
          w_state_next = ST_CLEAR;
          w_idx_next   = '0;
        end
      end
      ST_CLEAR: begin
        if (bus.i_clear) begin
          w_clr_idx = '0;
        end
        if (w_clr_idx == AW'(NREGS - 1)) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = w_clr_idx + 1'b1;
        end
      end
    endcase
  end

  // State and sweep index; reset lands directly in a fresh sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Per-entry decode of which agent touches each register this cycle.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
    assign w_clr_hit[gi] = w_in_clear && (w_clr_idx == AW'(gi));
    assign w_wr0_hit[gi] = w_wr0_act && (bus.i_wr0_addr == AW'(gi));
    assign w_wr1_hit[gi] = w_wr1_act && (bus.i_wr1_addr == AW'(gi));
    assign w_iss_hit[gi] = w_iss_act && (bus.i_issue_rd == AW'(gi));
  end

  // Array update: clear sweep, else wr1 over wr0 on an address collision.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (w_clr_hit[i]) begin
        r_mem[i] <= '0;
      end else if (w_wr1_hit[i]) begin
        r_mem[i] <= bus.i_wr1_data;
      end else if (w_wr0_hit[i]) begin
        r_mem[i] <= bus.i_wr0_data;
      end
    end
  end

  // Busy next: sweep clears; a same-cycle issue beats a retiring write
  // because the issued instruction is the younger producer.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (w_clr_hit[i]) begin
        w_busy_next[i] = 1'b0;
      end else if (w_iss_hit[i]) begin
        w_busy_next[i] = 1'b1;
      end else if (w_wr0_hit[i] || w_wr1_hit[i]) begin
        w_busy_next[i] = 1'b0;
      end
    end
  end

  // Scoreboard register, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // Two identical combinational read ports.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = (gi == 0) ? bus.i_rs1_addr : bus.i_rs2_addr;

    // Read mux: zero during a sweep, for x0 and for nonexistent entries.
    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if ((r_state == ST_IDLE) && f_writable(w_addr)) begin
        w_data = r_mem[w_addr];
        w_busy = r_busy[w_addr];
`ifdef REGFILE_SB_BYPASS_EN
        if (w_wr1_act && (bus.i_wr1_addr == w_addr)) begin
          w_data = bus.i_wr1_data;
          w_busy = 1'b0;
        end else if (w_wr0_act && (bus.i_wr0_addr == w_addr)) begin
          w_data = bus.i_wr0_data;
          w_busy = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.o_rs1_data   = g_rd[0].w_data;
  assign bus.o_rs1_busy   = g_rd[0].w_busy;
  assign bus.o_rs2_data   = g_rd[1].w_data;
  assign bus.o_rs2_busy   = g_rd[1].w_busy;
  assign bus.o_clear_busy = w_in_clear;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vectors for regfile_sb; the stimulus pushes the
// expected read-port/clear_busy values for each cycle into a queue and an
// independent monitor pops and compares them on the falling edge.
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [31:0] d1;
    logic        b1;
    logic [31:0] d2;
    logic        b2;
    logic        cb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  exp_t        q[$];

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got === req) n_pass++;
    else $display("FAIL %s cyc=%0d got=%08h required=%08h", nm, cyc, got, req);
  endtask

  // Monitor: compare every expectation due this cycle; stale ones fail.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc) begin
        chk({e.name, ".stale"}, 32'(cyc), 32'(e.cyc));
      end else begin
        chk({e.name, ".rs1_data"}, bus.o_rs1_data, e.d1);
        chk({e.name, ".rs1_busy"}, 32'(bus.o_rs1_busy), 32'(e.b1));
        chk({e.name, ".rs2_data"}, bus.o_rs2_data, e.d2);
        chk({e.name, ".rs2_busy"}, 32'(bus.o_rs2_busy), 32'(e.b2));
        chk({e.name, ".clear_busy"}, 32'(bus.o_clear_busy), 32'(e.cb));
        $display("txn %-16s cyc=%0d rs1=%08h/%0b rs2=%08h/%0b cb=%0b", e.name, cyc,
                 bus.o_rs1_data, bus.o_rs1_busy, bus.o_rs2_data, bus.o_rs2_busy, bus.o_clear_busy);
      end
    end
  end

  task automatic expect_rd(input string nm, input logic [31:0] d1, input logic b1,
                           input logic [31:0] d2, input logic b2, input logic cb);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.cb = cb;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.i_clear = 1'b0; bus.i_rs1_addr = '0; bus.i_rs2_addr = '0;
    bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0;
    bus.i_wr0_en = 1'b0; bus.i_wr0_addr = '0; bus.i_wr0_data = '0;
    bus.i_wr1_en = 1'b0; bus.i_wr1_addr = '0; bus.i_wr1_data = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus.i_wr0_en = 1'b1; bus.i_wr0_addr = a; bus.i_wr0_data = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.i_wr1_en = 1'b1; bus.i_wr1_addr = a; bus.i_wr1_data = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus.i_issue_valid = 1'b1; bus.i_issue_rd = a;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.i_rs1_addr = a1; bus.i_rs2_addr = a2;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    tick();
    expect_rd("in_reset", 0, 0, 0, 0, 1);
    tick();
    rst_n = 1'b1;

    // Sweep after reset: 32 busy cycles; a write/issue to x2 mid-sweep is ignored.
    for (int k = 0; k < NREGS; k++) begin
      idle_in(); rd(5, 3);
      if (k == 5) begin wr0(2, 32'hAAAA_AAAA); issue(2); end
      expect_rd($sformatf("sweep0_%0d", k), 0, 0, 0, 0, 1);
      tick();
    end
    idle_in(); rd(5, 2);
    expect_rd("post_reset", 0, 0, 0, 0, 0);
    tick();

    // Write x3 with a same-cycle read.
    idle_in(); rd(3, 4); wr0(3, 32'hDEAD_BEEF);
    expect_rd("wr_x3_same", BYP ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0, 0);
    tick();
    idle_in(); rd(3, 4);
    expect_rd("wr_x3_next", 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();

    // Same-address collision: wr1 wins.
    idle_in(); rd(7, 7); wr0(7, 32'h1111_1111); wr1(7, 32'h2222_2222);
    expect_rd("coll_x7_same", BYP ? 32'h2222_2222 : 32'h0, 0, BYP ? 32'h2222_2222 : 32'h0, 0, 0);
    tick();
    idle_in(); rd(7, 7);
    expect_rd("coll_x7_next", 32'h2222_2222, 0, 32'h2222_2222, 0, 0);
    tick();

    // Two ports to distinct addresses.
    idle_in(); wr0(10, 32'h0000_00A0); wr1(11, 32'h0000_00B1);
    tick();
    idle_in(); rd(10, 11);
    expect_rd("dual_wr", 32'h0000_00A0, 0, 32'h0000_00B1, 0, 0);
    tick();

    // Scoreboard: issue, write+issue (set wins), plain write clears.
    idle_in(); rd(9, 9); issue(9);
    expect_rd("iss_x9_same", 0, 0, 0, 0, 0);
    tick();
    idle_in(); rd(9, 9);
    expect_rd("iss_x9_next", 0, 1, 0, 1, 0);
    tick();
    idle_in(); rd(9, 1); wr0(9, 32'h0000_0099); issue(9);
    expect_rd("wr_iss_x9_same", BYP ? 32'h99 : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 0);
    tick();
    idle_in(); rd(9, 1);
    expect_rd("wr_iss_x9_next", 32'h0000_0099, 1, 0, 0, 0);
    tick();
    idle_in(); rd(9, 1); wr1(9, 32'h0000_009A);
    expect_rd("wr_x9_same", BYP ? 32'h9A : 32'h99, BYP ? 1'b0 : 1'b1, 0, 0, 0);
    tick();
    idle_in(); rd(9, 1);
    expect_rd("wr_x9_next", 32'h0000_009A, 0, 0, 0, 0);
    tick();

    // x0 is hardwired: writes and issue have no effect.
    idle_in(); rd(0, 0); wr0(0, 32'hFFFF_FFFF); wr1(0, 32'h1234_5678); issue(0);
    expect_rd("x0_same", 0, 0, 0, 0, 0);
    tick();
    idle_in(); rd(0, 0);
    expect_rd("x0_next", 0, 0, 0, 0, 0);
    tick();

    // Fill x1..x4 (x4 also marked busy), then flush.
    idle_in(); wr0(1, 32'h0000_0101); wr1(2, 32'h0000_0202);
    tick();
    idle_in(); wr0(3, 32'h0000_0303); wr1(4, 32'h0000_0404); issue(4);
    tick();
    idle_in(); rd(1, 4);
    expect_rd("fill_chk", 32'h0000_0101, 0, 32'h0000_0404, 1, 0);
    tick();
    // Flush cycle: the same-cycle write to x3 is dropped, so no forwarding.
    idle_in(); rd(3, 2); bus.i_clear = 1'b1; wr0(3, 32'h0000_0BAD);
    expect_rd("clear_pulse", 32'h0000_0303, 0, 32'h0000_0202, 0, 0);
    tick();
    for (int k = 0; k < NREGS; k++) begin
      idle_in(); rd(1, 2);
      if (k == 16) begin wr0(2, 32'h0000_BAD0); issue(2); end
      expect_rd($sformatf("sweep1_%0d", k), 0, 0, 0, 0, 1);
      tick();
    end
    idle_in(); rd(1, 2);
    expect_rd("post_clr_12", 0, 0, 0, 0, 0);
    tick();
    idle_in(); rd(3, 4);
    expect_rd("post_clr_34", 0, 0, 0, 0, 0);
    tick();

    // Flush again and re-flush at sweep index 10: 10 + 32 busy cycles.
    idle_in(); bus.i_clear = 1'b1;
    expect_rd("clear2_pulse", 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 10 + NREGS; k++) begin
      idle_in(); rd(1, 2);
      bus.i_clear = (k == 10);
      expect_rd($sformatf("sweep2_%0d", k), 0, 0, 0, 0, 1);
      tick();
    end
    idle_in();
    expect_rd("sweep2_end", 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset mid-cycle restarts the sweep immediately.
    idle_in(); wr0(6, 32'h0000_0066);
    tick();
    idle_in(); rd(6, 0);
    expect_rd("x6_written", 32'h0000_0066, 0, 0, 0, 0);
    tick();
    idle_in(); rd(6, 0); rst_n = 1'b0;
    expect_rd("async_rst", 0, 0, 0, 0, 1);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NREGS; k++) begin
      idle_in(); rd(6, 0);
      expect_rd($sformatf("sweep3_%0d", k), 0, 0, 0, 0, 1);
      tick();
    end
    idle_in(); rd(6, 0);
    expect_rd("x6_after_rst", 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();

    // Every expectation must have been consumed by the monitor.
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
